// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//
// Converts requester commands into cycles on a synchronous single-port
// memory. A write command is a single word. A read command is a burst of
// req_len+1 words at incrementing addresses. Each read beat takes three
// states: issue the address, wait out the memory's one-cycle read latency,
// then hold the word for the requester until it is consumed.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  command handshake (accepted only in IDLE)
//   req_we               1 = single-word write, 0 = burst read
//   req_addr             start address
//   req_wdata            write data (writes only)
//   req_len              read beats minus one (reads only)
//   resp_valid/ready     read-word handshake
//   resp_rdata           read word, stable while resp_valid
//   resp_last            marks the final beat of a burst
//   busy                 high whenever the FSM is not idle
//   mem_addr             memory address (holds its value between cycles)
//   mem_data_in          memory write data (holds its value between writes)
//   mem_data_out         memory registered read data; may float when unread
//   mem_we, mem_oe       memory write enable / output enable
// -----------------------------------------------------------------------------
module mem_master #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int LEN_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic [LEN_SIZE-1:0]  req_len,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_last,
    output logic                 busy,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    input  logic [WORD_SIZE-1:0] mem_data_out,
    output logic                 mem_we,
    output logic                 mem_oe
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPTURE,
        RD_HOLD
    } state_t;

    state_t               state_reg, state_next;
    logic [ADDR_SIZE-1:0] addr_reg,  addr_next;
    logic [WORD_SIZE-1:0] wdata_reg, wdata_next;
    logic [WORD_SIZE-1:0] rdata_reg, rdata_next;
    logic [LEN_SIZE-1:0]  len_reg,   len_next;
    logic [LEN_SIZE-1:0]  beat_reg,  beat_next;
    logic                 last_beat;

    // Memory-side address and write data come straight from registers that
    // only change when a new cycle is about to be driven, so they naturally
    // hold their last value through IDLE, RD_CAPTURE and RD_HOLD.
    assign mem_addr    = addr_reg;
    assign mem_data_in = wdata_reg;
    assign resp_rdata  = rdata_reg;
    assign last_beat   = (beat_reg == len_reg);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        len_next   = len_reg;
        beat_next  = beat_reg;

        // rst_n is folded in so that req_ready is low throughout reset,
        // not only from the first clock edge onward.
        req_ready  = (state_reg == IDLE) && rst_n;
        busy       = (state_reg != IDLE);
        mem_we     = (state_reg == WRITE);
        mem_oe     = (state_reg == RD_ISSUE);
        resp_valid = (state_reg == RD_HOLD);
        resp_last  = (state_reg == RD_HOLD) && last_beat;

        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_next = req_addr;
                    len_next  = req_len;
                    beat_next = '0;
                    if (req_we) begin
                        // Write data is only captured for writes so that
                        // mem_data_in keeps the last written word across reads.
                        wdata_next = req_wdata;
                        state_next = WRITE;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            RD_ISSUE: begin
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                // The only state in which the memory bus is sampled.
                rdata_next = mem_data_out;
                state_next = RD_HOLD;
            end
            RD_HOLD: begin
                if (resp_ready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        // Address wraps naturally at 2^ADDR_SIZE.
                        beat_next  = beat_reg + 1'b1;
                        addr_next  = addr_reg + 1'b1;
                        state_next = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            len_reg   <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            len_reg   <= len_next;
            beat_reg  <= beat_next;
        end
    end

endmodule
